// File: rtl/red_pitaya_asg_ch_gen2.sv
// red_pitaya_asg_ch_gen2: buffered waveform channel with burst FSM, gain, offset and saturation.
// Define ASG_INTERP_EN to interpolate linearly between adjacent samples (adds two pipeline stages).
module red_pitaya_asg_ch_gen2 #(
  parameter int RSZ = 14,
  parameter int DW  = 14,
  parameter int FW  = 16
) (
  input  logic              dac_clk_i,
  input  logic              dac_rst_i,
  input  logic              trig_i,
  output logic              trig_done_o,
  output logic              busy_o,
  input  logic              buf_we_i,
  input  logic [RSZ-1:0]    buf_addr_i,
  input  logic [DW-1:0]     buf_wdata_i,
  output logic [DW-1:0]     buf_rdata_o,
  output logic [RSZ-1:0]    buf_rpnt_o,
  input  logic [RSZ+FW-1:0] set_size_i,
  input  logic [RSZ+FW-1:0] set_step_i,
  input  logic [RSZ+FW-1:0] set_ofs_i,
  input  logic              set_rst_i,
  input  logic              set_wrap_i,
  input  logic              set_zero_i,
  input  logic [DW-1:0]     set_amp_i,
  input  logic [DW-1:0]     set_dc_i,
  input  logic [DW-1:0]     set_last_i,
  input  logic [15:0]       set_ncyc_i,
  input  logic [15:0]       set_rnum_i,
  input  logic [31:0]       set_rdly_i,
  output logic [DW-1:0]     dac_o
);
`ifdef ASG_INTERP_EN
  localparam int L = 6;
`else
  localparam int L = 4;
`endif
  localparam int PW = RSZ + FW;
  typedef enum logic [1:0] {IDLE, RUN, DLY, LAST} state_t;
  state_t state, state_n;
  logic [PW-1:0] pnt, pnt_n;
  logic [PW:0] npnt, wpnt;
  logic [15:0] cyc_cnt, cyc_n, rep_cnt, rep_n;
  logic [31:0] dly_cnt, dly_n, dly_dec;
  logic trig_ok, pass_end;
  logic [DW-1:0] mem [2**RSZ];
  logic [L-2:0][1:0] st_p;
  logic signed [DW-1:0] smp;
  logic signed [2*DW:0] prod;
  logic signed [DW+1:0] mul, y;
  logic [DW-1:0] ysat;
  assign trig_ok = trig_i && !set_rst_i && (state == IDLE || state == LAST);
  assign busy_o = state == RUN || state == DLY;
  assign npnt = {1'b0, pnt} + {1'b0, set_step_i};
  assign wpnt = npnt - {1'b0, set_size_i} - (PW+1)'(1);
  assign pass_end = npnt > {1'b0, set_size_i};
  assign dly_dec = (dly_cnt == '0) ? '0 : dly_cnt - 32'd1;
  always_comb begin
    state_n = state;
    pnt_n = pnt;
    cyc_n = cyc_cnt;
    rep_n = rep_cnt;
    dly_n = dly_cnt;
    if (set_rst_i) state_n = IDLE;
    else if (trig_ok) begin
      state_n = RUN;
      pnt_n = set_ofs_i;
      cyc_n = set_ncyc_i;
      rep_n = set_rnum_i;
    end else if (state == RUN) begin
      pnt_n = pass_end ? (set_wrap_i ? wpnt[PW-1:0] : set_ofs_i) : npnt[PW-1:0];
      if (pass_end && cyc_cnt == 16'd1) begin
        state_n = (rep_cnt == '0) ? LAST : DLY;
        rep_n = (rep_cnt == '0) ? rep_cnt : rep_cnt - 16'd1;
        dly_n = set_rdly_i;
      end else if (pass_end && cyc_cnt > 16'd1) cyc_n = cyc_cnt - 16'd1;
    end else if (state == DLY) begin
      // the counter reaching zero ends the gap, so rdly cycles of gap (minimum one)
      dly_n = dly_dec;
      if (dly_dec == '0) begin
        state_n = RUN;
        pnt_n = set_ofs_i;
        cyc_n = set_ncyc_i;
      end
    end
  end
  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      state <= IDLE;
      pnt <= '0;
      cyc_cnt <= '0;
      rep_cnt <= '0;
      dly_cnt <= '0;
      trig_done_o <= 1'b0;
    end else begin
      state <= state_n;
      pnt <= pnt_n;
      cyc_cnt <= cyc_n;
      rep_cnt <= rep_n;
      dly_cnt <= dly_n;
      trig_done_o <= trig_ok;
    end
  end
`ifdef ASG_INTERP_EN
  logic [RSZ-1:0] rp1;
  logic [7:0] f1, f2;
  logic signed [DW-1:0] a, b, a3;
  logic signed [DW+9:0] ip, dif, fr;
  assign dif = (DW+10)'(b) - (DW+10)'(a);
  assign fr = (DW+10)'($signed({1'b0, f2}));
`endif
  always_ff @(posedge dac_clk_i) begin
    if (buf_we_i) mem[buf_addr_i] <= buf_wdata_i;
    buf_rdata_o <= mem[buf_addr_i];
`ifdef ASG_INTERP_EN
    a <= mem[buf_rpnt_o];
    b <= mem[rp1];
`else
    smp <= mem[buf_rpnt_o];
`endif
  end
  assign prod = (2*DW+1)'(smp) * (2*DW+1)'($signed({1'b0, set_amp_i}));
  assign y = mul + (DW+2)'($signed(set_dc_i));
  assign ysat = (y[DW+1:DW-1] == '0 || y[DW+1:DW-1] == '1) ? y[DW-1:0] : {y[DW+1], {(DW-1){~y[DW+1]}}};
  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      buf_rpnt_o <= '0;
      st_p <= '0;
      mul <= '0;
      dac_o <= '0;
`ifdef ASG_INTERP_EN
      rp1 <= '0;
      f1 <= '0;
      f2 <= '0;
      ip <= '0;
      a3 <= '0;
      smp <= '0;
`endif
    end else begin
      buf_rpnt_o <= pnt[PW-1:FW];
      st_p <= {st_p[L-3:0], state};
`ifdef ASG_INTERP_EN
      // neighbour of the last table entry is the first entry
      rp1 <= (pnt[PW-1:FW] == set_size_i[PW-1:FW]) ? '0 : pnt[PW-1:FW] + RSZ'(1);
      f1 <= pnt[FW-1:FW-8];
      f2 <= f1;
      ip <= dif * fr;
      a3 <= a;
      smp <= a3 + DW'(ip >>> 8);
`endif
      mul <= (DW+2)'(prod >>> (DW-1));
      dac_o <= set_zero_i ? '0 : (st_p[L-2] == RUN) ? ysat : (st_p[L-2] == DLY || st_p[L-2] == LAST) ? set_last_i : '0;
    end
  end
endmodule

// File: tb/tb_red_pitaya_asg_ch_gen2.sv
// tb_red_pitaya_asg_ch_gen2: scoreboard and vector-table bench for the waveform generator channel.
`timescale 1ns/1ps
module tb_red_pitaya_asg_ch_gen2;
  localparam int RSZ = 14;
  localparam int DW = 14;
  localparam int FW = 16;
  localparam int PW = RSZ + FW;
`ifdef ASG_INTERP_EN
  localparam int L = 6;
`else
  localparam int L = 4;
`endif
  localparam int SZ7 = (7 << FW) | 'hFFFF;
  localparam int SZ63 = (63 << FW) | 'hFFFF;
  logic dac_clk = 1'b0;
  logic dac_rst, trig_i, trig_done_o, busy_o, buf_we_i;
  logic [RSZ-1:0] buf_addr_i, buf_rpnt_o;
  logic [DW-1:0] buf_wdata_i, buf_rdata_o, set_amp_i, set_dc_i, set_last_i, dac_o;
  logic [PW-1:0] set_size_i, set_step_i, set_ofs_i;
  logic set_rst_i, set_wrap_i, set_zero_i;
  logic [15:0] set_ncyc_i, set_rnum_i;
  logic [31:0] set_rdly_i;
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  typedef struct {int smp; int amp; int dc; bit zero; int exp;} vec_t;
  vec_t tv [14];
  red_pitaya_asg_ch_gen2 #(.RSZ(RSZ), .DW(DW), .FW(FW)) dut (
    .dac_clk_i(dac_clk), .dac_rst_i(dac_rst), .trig_i(trig_i), .trig_done_o(trig_done_o),
    .busy_o(busy_o), .buf_we_i(buf_we_i), .buf_addr_i(buf_addr_i), .buf_wdata_i(buf_wdata_i),
    .buf_rdata_o(buf_rdata_o), .buf_rpnt_o(buf_rpnt_o), .set_size_i(set_size_i),
    .set_step_i(set_step_i), .set_ofs_i(set_ofs_i), .set_rst_i(set_rst_i), .set_wrap_i(set_wrap_i),
    .set_zero_i(set_zero_i), .set_amp_i(set_amp_i), .set_dc_i(set_dc_i), .set_last_i(set_last_i),
    .set_ncyc_i(set_ncyc_i), .set_rnum_i(set_rnum_i), .set_rdly_i(set_rdly_i), .dac_o(dac_o)
  );
  always #5 dac_clk = ~dac_clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  function automatic int sdac();
    return int'($signed(dac_o));
  endfunction
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic write_buf(input int a, input int d);
    @(posedge dac_clk);
    #1;
    buf_we_i = 1'b1;
    buf_addr_i = RSZ'(a);
    buf_wdata_i = DW'(d);
    @(posedge dac_clk);
    #1;
    buf_we_i = 1'b0;
  endtask
  task automatic read_chk(input string name, input int a, input int exp);
    buf_addr_i = RSZ'(a);
    @(posedge dac_clk);
    @(negedge dac_clk);
    check(name, int'(buf_rdata_o), exp);
  endtask
  task automatic cfg(input int size, input int ofs, input int step, input int ncyc, input int rnum,
                     input int rdly, input bit wrap);
    @(posedge dac_clk);
    #1;
    set_size_i = PW'(size);
    set_ofs_i = PW'(ofs);
    set_step_i = PW'(step);
    set_ncyc_i = 16'(ncyc);
    set_rnum_i = 16'(rnum);
    set_rdly_i = 32'(rdly);
    set_wrap_i = wrap;
  endtask
  task automatic pulse_trig();
    @(posedge dac_clk);
    #1;
    trig_i = 1'b1;
    @(posedge dac_clk);
    #1;
    trig_i = 1'b0;
  endtask
  task automatic push_n(input int v, input int k);
    for (int j = 0; j < k; j++) exp_q.push_back(v);
  endtask
  task automatic push_ramp();
    for (int j = 0; j < 8; j++) exp_q.push_back(j);
  endtask
  // compares dac_o each cycle against the scoreboard; trig_i held over [trig_at,trig_end), set_rst_i+trig_i at srst_at
  task automatic run_stream(input string name, input int n, input int trig_at, input int trig_end,
                            input int srst_at, input int exp_busy, input int rp_at, input int rp_exp);
    int busy_n = 0;
    int done_n = 0;
    check({name, "_sb_len"}, exp_q.size(), n);
    for (int i = 0; i < n; i++) begin
      @(negedge dac_clk);
      if (exp_q.size() > 0) check($sformatf("%s_dac[%0d]", name, i), sdac(), exp_q.pop_front());
      busy_n += int'(busy_o);
      done_n += int'(trig_done_o);
      if (i == rp_at) check({name, "_rpnt"}, int'(buf_rpnt_o), rp_exp);
      trig_i = (i >= trig_at && i < trig_end) || i == srst_at;
      set_rst_i = (i == srst_at);
    end
    @(posedge dac_clk);
    #1;
    trig_i = 1'b0;
    set_rst_i = 1'b0;
    check({name, "_busy_cycles"}, busy_n, exp_busy);
    check({name, "_trig_done"}, done_n, 1);
  endtask
  initial begin
    int bz, nz;
    tv[0] = '{100, 'h2000, 0, 1'b0, 100};
    tv[1] = '{100, 'h1000, 0, 1'b0, 50};
    tv[2] = '{-100, 'h2000, 50, 1'b0, -50};
    tv[3] = '{8191, 'h3FFF, 100, 1'b0, 8191};
    tv[4] = '{-8192, 'h3FFF, -100, 1'b0, -8192};
    tv[5] = '{1000, 'h2000, -3000, 1'b0, -2000};
    tv[6] = '{-7, 'h1000, 0, 1'b0, -4};
    tv[7] = '{4000, 'h3000, 3000, 1'b0, 8191};
    tv[8] = '{123, 'h2000, 0, 1'b1, 0};
    tv[9] = '{0, 'h2000, -8192, 1'b0, -8192};
    tv[10] = '{8191, 'h2000, 0, 1'b0, 8191};
    tv[11] = '{5, 0, 7, 1'b0, 7};
    tv[12] = '{-8192, 'h2000, -1, 1'b0, -8192};
    tv[13] = '{-3000, 'h2000, -6000, 1'b0, -8192};
    dac_rst = 1'b1;
    trig_i = 1'b0;
    buf_we_i = 1'b0;
    buf_addr_i = '0;
    buf_wdata_i = '0;
    set_size_i = '0;
    set_step_i = '0;
    set_ofs_i = '0;
    set_rst_i = 1'b0;
    set_wrap_i = 1'b0;
    set_zero_i = 1'b0;
    set_amp_i = 14'h2000;
    set_dc_i = '0;
    set_last_i = 14'd77;
    set_ncyc_i = '0;
    set_rnum_i = '0;
    set_rdly_i = '0;
    repeat (3) @(posedge dac_clk);
    @(negedge dac_clk);
    check("rst_dac", sdac(), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_trig_done", int'(trig_done_o), 0);
    check("rst_rpnt", int'(buf_rpnt_o), 0);
    @(posedge dac_clk);
    #1;
    dac_rst = 1'b0;
    for (int i = 0; i < 16; i++) write_buf(i, i);
    write_buf(9, 99);
    read_chk("rd_after_wr", 9, 99);
    write_buf(9, 9);
    read_chk("rd_ramp", 5, 5);
    // two passes of an 8-entry ramp, then the idle value
    cfg(SZ7, 0, 1 << FW, 2, 0, 0, 1'b0);
    push_n(0, L);
    push_ramp();
    push_ramp();
    push_n(77, 6);
    pulse_trig();
    run_stream("single", L + 22, -1, -1, -1, 16, 5, 4);
    // three bursts with 10-cycle gaps; retriggers during RUN and DLY are ignored
    cfg(SZ7, 0, 1 << FW, 1, 2, 10, 1'b0);
    push_n(77, L);
    push_ramp();
    push_n(77, 10);
    push_ramp();
    push_n(77, 10);
    push_ramp();
    push_n(77, 6);
    pulse_trig();
    run_stream("burst", L + 50, 3, 13, -1, 44, -1, 0);
    // set_rst_i together with trig_i while running
    cfg(SZ7, 0, 1 << FW, 0, 0, 0, 1'b0);
    push_n(77, L);
    for (int j = 0; j < 6; j++) exp_q.push_back(j);
    push_n(0, 4);
    pulse_trig();
    run_stream("srst_trig", L + 10, -1, -1, 5, 6, -1, 0);
    // wrap keeps the fractional overshoot: 0,3,6,1,4,7,2,5,0,3
    cfg(SZ7, 0, 3 << FW, 0, 0, 0, 1'b1);
    push_n(0, L);
    for (int j = 0; j < 10; j++) exp_q.push_back((3 * j) % 8);
    pulse_trig();
    run_stream("wrap", L + 10, -1, -1, L + 9, L + 10, -1, 0);
    repeat (L + 2) @(posedge dac_clk);
    // datapath vectors: play address 20 continuously and rewrite it while running
    cfg(SZ63, 20 << FW, 0, 0, 0, 0, 1'b0);
    pulse_trig();
    for (int k = 0; k < 14; k++) begin
      @(posedge dac_clk);
      #1;
      buf_we_i = 1'b1;
      buf_addr_i = RSZ'(20);
      buf_wdata_i = DW'(tv[k].smp);
      set_amp_i = DW'(tv[k].amp);
      set_dc_i = DW'(tv[k].dc);
      set_zero_i = tv[k].zero;
      exp_q.push_back(tv[k].exp);
      @(posedge dac_clk);
      #1;
      buf_we_i = 1'b0;
      repeat (L + 3) @(posedge dac_clk);
      @(negedge dac_clk);
      check($sformatf("dp_vec%0d", k), sdac(), exp_q.pop_front());
    end
    check("dp_rpnt", int'(buf_rpnt_o), 20);
    @(posedge dac_clk);
    #1;
    set_rst_i = 1'b1;
    set_amp_i = 14'h2000;
    set_dc_i = '0;
    set_zero_i = 1'b0;
    @(posedge dac_clk);
    #1;
    set_rst_i = 1'b0;
    repeat (L + 2) @(posedge dac_clk);
`ifdef ASG_INTERP_EN
    write_buf(0, 0);
    write_buf(1, 256);
    write_buf(2, 512);
    cfg(SZ63, 0, 1 << (FW - 2), 0, 0, 0, 1'b0);
    push_n(0, L);
    for (int j = 0; j < 5; j++) exp_q.push_back(64 * j);
    pulse_trig();
    run_stream("interp", L + 5, -1, -1, L + 4, L + 5, -1, 0);
    repeat (L + 2) @(posedge dac_clk);
`endif
    // asynchronous reset mid-burst
    cfg(SZ7, 0, 1 << FW, 0, 0, 0, 1'b0);
    pulse_trig();
    repeat (5) @(posedge dac_clk);
    @(negedge dac_clk);
    check("busy_pre_rst", int'(busy_o), 1);
    #1;
    dac_rst = 1'b1;
    #1;
    check("arst_dac", sdac(), 0);
    check("arst_busy", int'(busy_o), 0);
    check("arst_trig_done", int'(trig_done_o), 0);
    check("arst_rpnt", int'(buf_rpnt_o), 0);
    @(posedge dac_clk);
    #1;
    dac_rst = 1'b0;
    bz = 0;
    nz = 0;
    repeat (10) begin
      @(negedge dac_clk);
      bz += int'(busy_o);
      nz += int'(dac_o != '0);
    end
    check("post_rst_busy", bz, 0);
    check("post_rst_dac", nz, 0);
    @(posedge dac_clk);
    #1;
    read_chk("buf_kept", 3, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
